demux32_stream: RTL and testbench

DEMUX32_STREAM -- requirements
Module: demux32_stream

---
 rtl/demux32_stream.sv | 129 ++++++++++++
 tb/tb_demux32_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux32_stream.sv
// demux32_stream: one input stream routed by in_sel into two independent
// in-order channel buffers (A and B), each DEPTH entries deep with a
// registered head word and 1-cycle push-to-visible latency.

// Single channel buffer: circular storage with wrapping read/write pointers.
module demux32_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    ready,
  output logic                    valid,
  output logic [WIDTH-1:0]        data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid = (count_q != '0);
  assign pop   = valid & ready;
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign data  = mem[rd_ptr];

  // Pointer, occupancy and storage update; reset wins over push and pop.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every register samples pre-edge values.
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      // NOTE: storage is cleared on reset so the head word reads 0 afterwards.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// Top level: in_ready follows only the selected channel's full flag, so a
// full selected channel stalls the stream even if the other one has space.
module demux32_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_sel,
  output logic                    in_ready,
  output logic                    a_valid,
  output logic [WIDTH-1:0]        a_data,
  input  logic                    a_ready,
  output logic [$clog2(DEPTH):0]  a_count,
  output logic                    b_valid,
  output logic [WIDTH-1:0]        b_data,
  input  logic                    b_ready,
  output logic [$clog2(DEPTH):0]  b_count
);

  if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_bad_depth
    $error("demux32_stream: DEPTH must be 2, 4 or 8");
  end

  logic a_full;
  logic b_full;
  logic a_push;
  logic b_push;

  // No look-ahead on the downstream ready: a full channel never accepts.
  assign in_ready = in_sel ? ~b_full : ~a_full;
  assign a_push   = in_valid & in_ready & ~in_sel;
  assign b_push   = in_valid & in_ready &  in_sel;

  demux32_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_push),
    .push_data (in_data),
    .ready     (a_ready),
    .valid     (a_valid),
    .data      (a_data),
    .count     (a_count),
    .full      (a_full)
  );

  demux32_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_b (
    .clk       (clk),
    .rst       (rst),
    .push      (b_push),
    .push_data (in_data),
    .ready     (b_ready),
    .valid     (b_valid),
    .data      (b_data),
    .count     (b_count),
    .full      (b_full)
  );

endmodule

// File: tb/tb_demux32_stream.sv
// Bench for demux32_stream: queue scoreboard per channel plus directed checks.
module tb_demux32_stream;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_ready;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic [CW-1:0]    a_count;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic [CW-1:0]    b_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic             chk_en = 1'b0;
  logic [WIDTH-1:0] exp_a[$];
  logic [WIDTH-1:0] exp_b[$];
  logic             model_ready;
  logic             push_done;

  demux32_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_ready (in_ready),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .a_count  (a_count),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT against the queues, then predict the coming edge.
  always @(negedge clk) begin
    model_ready = in_sel ? (exp_b.size() != DEPTH) : (exp_a.size() != DEPTH);
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(model_ready));
      check("a_count", 64'(a_count), 64'(exp_a.size()));
      check("b_count", 64'(b_count), 64'(exp_b.size()));
      check("a_valid", 64'(a_valid), 64'(exp_a.size() != 0));
      check("b_valid", 64'(b_valid), 64'(exp_b.size() != 0));
      if (exp_a.size() != 0) check("a_data", 64'(a_data), 64'(exp_a[0]));
      if (exp_b.size() != 0) check("b_data", 64'(b_data), 64'(exp_b[0]));
    end
    if (rst) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (a_ready && exp_a.size() != 0) void'(exp_a.pop_front());
      if (b_ready && exp_b.size() != 0) void'(exp_b.pop_front());
      if (in_valid && model_ready) begin
        if (in_sel) exp_b.push_back(in_data);
        else        exp_a.push_back(in_data);
      end
    end
  end

  // Present one word and hold it until accepted, within a cycle budget.
  task automatic push_word(input logic sel, input logic [WIDTH-1:0] d);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    for (int k = 0; k < 64; k++) begin
      #1;
      acc = in_ready;
      tick();
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: got not-accepted expected accepted for 0x%0h", d);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 1'b0;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    push_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state.
    check("rst_a_valid", 64'(a_valid), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_a_data", 64'(a_data), 64'd0);
    check("rst_b_data", 64'(b_data), 64'd0);
    check("rst_a_count", 64'(a_count), 64'd0);
    check("rst_b_count", 64'(b_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    chk_en = 1'b1;

    // Routing: one word to each channel, each visible for one cycle.
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1111_1111;
    tick();
    check("route_a_valid", 64'(a_valid), 64'd1);
    check("route_a_data", 64'(a_data), 64'h1111_1111);
    check("route_b_idle", 64'(b_valid), 64'd0);
    in_sel = 1'b1; in_data = 32'h2222_2222;
    tick();
    check("route_a_gone", 64'(a_valid), 64'd0);
    check("route_b_valid", 64'(b_valid), 64'd1);
    check("route_b_data", 64'(b_data), 64'h2222_2222);
    in_valid = 1'b0;
    tick();
    check("route_b_gone", 64'(b_valid), 64'd0);

    // Full stall on channel A.
    a_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA0;
    tick();
    in_data = 32'hA1;
    tick();
    in_data = 32'hA2;
    #1;
    check("stall_a_count", 64'(a_count), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("stall_hold_count", 64'(a_count), 64'd2);
    a_ready = 1'b1;
    #1;
    check("stall_no_passthru", 64'(in_ready), 64'd0);
    tick();
    a_ready = 1'b0;
    #1;
    check("stall_after_pop_count", 64'(a_count), 64'd1);
    check("stall_after_pop_head", 64'(a_data), 64'hA1);
    check("stall_after_pop_ready", 64'(in_ready), 64'd1);
    tick();
    check("stall_accept_count", 64'(a_count), 64'd2);
    in_valid = 1'b0; a_ready = 1'b1;
    tick();
    tick();
    check("stall_drained", 64'(a_count), 64'd0);

    // Head-of-line block: B word waits behind a blocked A word.
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hC0;
    tick();
    in_data = 32'hC1;
    tick();
    in_data = 32'hC2;
    #1;
    check("hol_blocked", 64'(in_ready), 64'd0);
    tick();
    check("hol_b_empty", 64'(b_count), 64'd0);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    #1;
    check("hol_a_drained_one", 64'(a_count), 64'd1);
    tick();
    in_sel = 1'b1; in_data = 32'hD0;
    #1;
    check("hol_b_ready", 64'(in_ready), 64'd1);
    tick();
    check("hol_b_valid", 64'(b_valid), 64'd1);
    check("hol_b_data", 64'(b_data), 64'hD0);
    check("hol_a_full", 64'(a_count), 64'd2);
    in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    tick();
    tick();
    check("hol_a_empty", 64'(a_count), 64'd0);
    check("hol_b_empty_end", 64'(b_count), 64'd0);

    // Wrap and order on channel B with random downstream ready.
    b_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) push_word(1'b1, WIDTH'(i));
        in_valid  = 1'b0;
        push_done = 1'b1;
      end
      begin
        for (int c = 0; c < 2000 && !push_done; c++) begin
          @(posedge clk);
          #1;
          b_ready = 1'($urandom_range(0, 1));
          check("wrap_b_count_max", 64'(b_count <= CW'(DEPTH)), 64'd1);
        end
      end
    join
    b_ready = 1'b1;
    repeat (4) tick();
    check("wrap_b_drained", 64'(b_count), 64'd0);

    // Simultaneous push and pop at a_count=1.
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hE0;
    tick();
    in_data = 32'hE1; a_ready = 1'b1;
    tick();
    check("pushpop_count", 64'(a_count), 64'd1);
    check("pushpop_head", 64'(a_data), 64'hE1);
    in_valid = 1'b0;
    tick();
    a_ready = 1'b0;
    check("pushpop_drained", 64'(a_count), 64'd0);

    // Mid-stream reset discards buffered words and a concurrent push.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hF0;
    tick();
    in_data = 32'hF1;
    tick();
    in_sel = 1'b1; in_data = 32'h60;
    tick();
    check("mid_a_count", 64'(a_count), 64'd2);
    check("mid_b_count", 64'(b_count), 64'd1);
    rst = 1'b1; in_data = 32'h61; a_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; a_ready = 1'b0;
    #1;
    check("mid_rst_a_count", 64'(a_count), 64'd0);
    check("mid_rst_b_count", 64'(b_count), 64'd0);
    check("mid_rst_a_valid", 64'(a_valid), 64'd0);
    check("mid_rst_b_valid", 64'(b_valid), 64'd0);
    check("mid_rst_a_data", 64'(a_data), 64'd0);
    check("mid_rst_b_data", 64'(b_data), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);

    // Idle input: data and select ignored while in_valid=0.
    in_sel = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    in_sel = 1'b0;
    tick();
    check("idle_a_count", 64'(a_count), 64'd0);
    check("idle_b_count", 64'(b_count), 64'd0);
    check("idle_b_valid", 64'(b_valid), 64'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
